// File: rtl/exu_lsu_ctrl.sv
// Load/store control stage: alignment check, byte-masked bus issue, in-order
// outstanding-request FIFO and load-data alignment/extension for write-back.
module exu_lsu_ctrl #(
    parameter int OUTS_DEPTH = 2,
    parameter int XLEN       = 32,
    parameter int ADDR_SIZE  = 32,
    parameter int ITAG_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  agu_cmd_valid,
    output logic                  agu_cmd_ready,
    input  logic [ADDR_SIZE-1:0]  agu_cmd_addr,
    input  logic                  agu_cmd_read,
    input  logic [XLEN-1:0]       agu_cmd_wdata,
    input  logic [1:0]            agu_cmd_size,
    input  logic                  agu_cmd_usign,
    input  logic [ITAG_WIDTH-1:0] agu_cmd_itag,

    output logic                  lsu_icb_cmd_valid,
    input  logic                  lsu_icb_cmd_ready,
    output logic [ADDR_SIZE-1:0]  lsu_icb_cmd_addr,
    output logic                  lsu_icb_cmd_read,
    output logic [XLEN-1:0]       lsu_icb_cmd_wdata,
    output logic [3:0]            lsu_icb_cmd_wmask,

    input  logic                  lsu_icb_rsp_valid,
    output logic                  lsu_icb_rsp_ready,
    input  logic [XLEN-1:0]       lsu_icb_rsp_rdata,
    input  logic                  lsu_icb_rsp_err,

    output logic                  lsu_o_valid,
    input  logic                  lsu_o_ready,
    output logic [XLEN-1:0]       lsu_o_wbck_wdat,
    output logic [ITAG_WIDTH-1:0] lsu_o_wbck_itag,
    output logic                  lsu_o_wbck_err,
    output logic [ADDR_SIZE-1:0]  lsu_o_badaddr
);

    localparam int PTR_W = $clog2(OUTS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    typedef struct packed {
        logic [ITAG_WIDTH-1:0] itag;
        logic                  read;
        size_e                 size;
        logic                  usign;
        logic [ADDR_SIZE-1:0]  addr;
        logic                  mis;
    } entry_t;

    entry_t             fifo_mem [OUTS_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    logic               full;
    logic               empty;
    logic               misaligned;
    logic               push;
    logic               pop;
    entry_t             new_entry;
    entry_t             head;
    logic [XLEN-1:0]    rsp_shifted;
    logic [XLEN-1:0]    load_data;
    logic               head_load;

    assign full  = (count == CNT_W'(OUTS_DEPTH));
    assign empty = (count == '0);

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        misaligned        = 1'b0;
        lsu_icb_cmd_wmask = 4'b1111;
        case (size_e'(agu_cmd_size))
            SZ_BYTE: lsu_icb_cmd_wmask = 4'b0001 << agu_cmd_addr[1:0];
            SZ_HALF: begin
                misaligned        = agu_cmd_addr[0];
                lsu_icb_cmd_wmask = 4'b0011 << {agu_cmd_addr[1], 1'b0};
            end
            SZ_WORD: misaligned = |agu_cmd_addr[1:0];
            default: ;
        endcase
    end

    // A full FIFO blocks pushes even when the head pops this cycle.
    assign agu_cmd_ready     = ~full & (misaligned | lsu_icb_cmd_ready);
    assign push              = agu_cmd_valid & agu_cmd_ready;
    assign lsu_icb_cmd_valid = agu_cmd_valid & ~full & ~misaligned;
    assign lsu_icb_cmd_addr  = {agu_cmd_addr[ADDR_SIZE-1:2], 2'b00};
    assign lsu_icb_cmd_read  = agu_cmd_read;
    assign lsu_icb_cmd_wdata = agu_cmd_wdata;

    assign new_entry = '{itag:  agu_cmd_itag,
                         read:  agu_cmd_read,
                         size:  size_e'(agu_cmd_size),
                         usign: agu_cmd_usign,
                         addr:  agu_cmd_addr,
                         mis:   misaligned};

    // NOTE: the entry storage is not reset; pointers and count define validity, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= new_entry;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = fifo_mem[rd_ptr];

    // Misaligned entries answer locally and never consume a bus response.
    assign lsu_o_valid       = ~empty & (head.mis | lsu_icb_rsp_valid);
    assign lsu_icb_rsp_ready = ~empty & ~head.mis & lsu_o_ready;
    assign pop               = lsu_o_valid & lsu_o_ready;

    assign lsu_o_wbck_err  = ~empty & (head.mis | lsu_icb_rsp_err);
    assign lsu_o_badaddr   = lsu_o_wbck_err ? head.addr : '0;
    assign lsu_o_wbck_itag = empty ? '0 : head.itag;

    assign rsp_shifted = lsu_icb_rsp_rdata >> {head.addr[1:0], 3'b000};

    always_comb begin
        load_data = rsp_shifted;
        case (head.size)
            SZ_BYTE: load_data = head.usign ? XLEN'(rsp_shifted[7:0])
                                            : {{(XLEN-8){rsp_shifted[7]}}, rsp_shifted[7:0]};
            SZ_HALF: load_data = head.usign ? XLEN'(rsp_shifted[15:0])
                                            : {{(XLEN-16){rsp_shifted[15]}}, rsp_shifted[15:0]};
            default: ;
        endcase
    end

    assign head_load       = ~empty & ~head.mis & head.read & ~lsu_icb_rsp_err;
    assign lsu_o_wbck_wdat = head_load ? load_data : '0;

endmodule

// File: tb/tb_exu_lsu_ctrl.sv
// Scoreboard bench for exu_lsu_ctrl: expected write-backs are queued at command
// acceptance and compared as the DUT hands them to the write-back port.
module tb_exu_lsu_ctrl;

    localparam int XLEN  = 32;
    localparam int AW    = 32;
    localparam int TW    = 4;
    localparam int DEPTH = 2;

    logic            clk;
    logic            rst_n;
    logic            agu_cmd_valid;
    logic            agu_cmd_ready;
    logic [AW-1:0]   agu_cmd_addr;
    logic            agu_cmd_read;
    logic [XLEN-1:0] agu_cmd_wdata;
    logic [1:0]      agu_cmd_size;
    logic            agu_cmd_usign;
    logic [TW-1:0]   agu_cmd_itag;
    logic            lsu_icb_cmd_valid;
    logic            lsu_icb_cmd_ready;
    logic [AW-1:0]   lsu_icb_cmd_addr;
    logic            lsu_icb_cmd_read;
    logic [XLEN-1:0] lsu_icb_cmd_wdata;
    logic [3:0]      lsu_icb_cmd_wmask;
    logic            lsu_icb_rsp_valid;
    logic            lsu_icb_rsp_ready;
    logic [XLEN-1:0] lsu_icb_rsp_rdata;
    logic            lsu_icb_rsp_err;
    logic            lsu_o_valid;
    logic            lsu_o_ready;
    logic [XLEN-1:0] lsu_o_wbck_wdat;
    logic [TW-1:0]   lsu_o_wbck_itag;
    logic            lsu_o_wbck_err;
    logic [AW-1:0]   lsu_o_badaddr;

    exu_lsu_ctrl #(
        .OUTS_DEPTH(DEPTH), .XLEN(XLEN), .ADDR_SIZE(AW), .ITAG_WIDTH(TW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .agu_cmd_valid     (agu_cmd_valid),
        .agu_cmd_ready     (agu_cmd_ready),
        .agu_cmd_addr      (agu_cmd_addr),
        .agu_cmd_read      (agu_cmd_read),
        .agu_cmd_wdata     (agu_cmd_wdata),
        .agu_cmd_size      (agu_cmd_size),
        .agu_cmd_usign     (agu_cmd_usign),
        .agu_cmd_itag      (agu_cmd_itag),
        .lsu_icb_cmd_valid (lsu_icb_cmd_valid),
        .lsu_icb_cmd_ready (lsu_icb_cmd_ready),
        .lsu_icb_cmd_addr  (lsu_icb_cmd_addr),
        .lsu_icb_cmd_read  (lsu_icb_cmd_read),
        .lsu_icb_cmd_wdata (lsu_icb_cmd_wdata),
        .lsu_icb_cmd_wmask (lsu_icb_cmd_wmask),
        .lsu_icb_rsp_valid (lsu_icb_rsp_valid),
        .lsu_icb_rsp_ready (lsu_icb_rsp_ready),
        .lsu_icb_rsp_rdata (lsu_icb_rsp_rdata),
        .lsu_icb_rsp_err   (lsu_icb_rsp_err),
        .lsu_o_valid       (lsu_o_valid),
        .lsu_o_ready       (lsu_o_ready),
        .lsu_o_wbck_wdat   (lsu_o_wbck_wdat),
        .lsu_o_wbck_itag   (lsu_o_wbck_itag),
        .lsu_o_wbck_err    (lsu_o_wbck_err),
        .lsu_o_badaddr     (lsu_o_badaddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] wdat;
        logic [TW-1:0]   itag;
        logic            err;
        logic [AW-1:0]   badaddr;
    } wb_t;

    typedef struct {
        logic [XLEN-1:0] rdata;
        logic            err;
    } rsp_t;

    wb_t  exp_q[$];
    rsp_t bus_q[$];
    wb_t  mon_e;
    bit   rsp_en;
    bit   rsp_fire;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic bit is_mis(input logic [31:0] a, input logic [1:0] sz);
        return (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    endfunction

    function automatic logic [3:0] wmask_of(input logic [31:0] a, input logic [1:0] sz);
        case (sz)
            2'b00:   return 4'b0001 << a[1:0];
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Bus slave: returns queued responses in order while enabled.
    initial begin
        lsu_icb_rsp_valid = 1'b0;
        lsu_icb_rsp_rdata = '0;
        lsu_icb_rsp_err   = 1'b0;
        forever begin
            @(negedge clk);
            rsp_fire = lsu_icb_rsp_valid && lsu_icb_rsp_ready;
            @(posedge clk);
            #2;
            if (rsp_fire && bus_q.size() > 0) void'(bus_q.pop_front());
            if (rsp_en && bus_q.size() > 0) begin
                lsu_icb_rsp_valid = 1'b1;
                lsu_icb_rsp_rdata = bus_q[0].rdata;
                lsu_icb_rsp_err   = bus_q[0].err;
            end else begin
                lsu_icb_rsp_valid = 1'b0;
                lsu_icb_rsp_rdata = '0;
                lsu_icb_rsp_err   = 1'b0;
            end
        end
    end

    // Write-back monitor: pops the scoreboard on each lsu_o handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && lsu_o_valid && lsu_o_ready) begin
                if (exp_q.size() == 0) begin
                    check("wb_unexpected", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wb_wdat",    lsu_o_wbck_wdat, mon_e.wdat);
                    check("wb_itag",    lsu_o_wbck_itag, mon_e.itag);
                    check("wb_err",     lsu_o_wbck_err,  mon_e.err);
                    check("wb_badaddr", lsu_o_badaddr,   mon_e.badaddr);
                end
            end
        end
    end

    task automatic issue(input logic [31:0] addr, input logic rd, input logic [1:0] sz,
                         input logic us, input logic [31:0] wdata, input logic [3:0] tag,
                         input logic [31:0] rdata, input logic rerr,
                         input logic [31:0] exp_wdat, output int waited);
        bit   m;
        bit   done;
        wb_t  e;
        rsp_t r;
        m = is_mis(addr, sz);
        @(posedge clk);
        #1;
        agu_cmd_addr  = addr;
        agu_cmd_read  = rd;
        agu_cmd_size  = sz;
        agu_cmd_usign = us;
        agu_cmd_wdata = wdata;
        agu_cmd_itag  = tag;
        agu_cmd_valid = 1'b1;
        done   = 1'b0;
        waited = 0;
        while (!done && waited < 100) begin
            @(negedge clk);
            if (agu_cmd_ready) begin
                done = 1'b1;
                if (m) begin
                    check("no_bus_issue", lsu_icb_cmd_valid, 0);
                end else begin
                    check("bus_valid", lsu_icb_cmd_valid, 1);
                    check("bus_addr",  lsu_icb_cmd_addr,  {addr[31:2], 2'b00});
                    check("bus_wmask", lsu_icb_cmd_wmask, wmask_of(addr, sz));
                    check("bus_read",  lsu_icb_cmd_read,  rd);
                    if (!rd) check("bus_wdata", lsu_icb_cmd_wdata, wdata);
                    r.rdata = rdata;
                    r.err   = rerr;
                    bus_q.push_back(r);
                end
                e.itag    = tag;
                e.err     = m | rerr;
                e.wdat    = e.err ? 32'h0 : exp_wdat;
                e.badaddr = e.err ? addr : 32'h0;
                exp_q.push_back(e);
            end else begin
                waited++;
            end
        end
        if (!done) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        agu_cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int w;

    initial begin
        rst_n             = 1'b0;
        agu_cmd_valid     = 1'b0;
        agu_cmd_addr      = '0;
        agu_cmd_read      = 1'b1;
        agu_cmd_wdata     = '0;
        agu_cmd_size      = 2'b10;
        agu_cmd_usign     = 1'b0;
        agu_cmd_itag      = '0;
        lsu_icb_cmd_ready = 1'b1;
        lsu_o_ready       = 1'b1;
        rsp_en            = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_cmd_ready",  agu_cmd_ready, 1);
        check("rst_bus_valid",  lsu_icb_cmd_valid, 0);
        check("rst_o_valid",    lsu_o_valid, 0);
        check("rst_rsp_ready",  lsu_icb_rsp_ready, 0);
        check("rst_err",        lsu_o_wbck_err, 0);
        check("rst_badaddr",    lsu_o_badaddr, 0);
        lsu_icb_cmd_ready = 1'b0;
        #1;
        check("rst_cmd_ready_busy", agu_cmd_ready, 0);
        @(posedge clk);
        #1;
        lsu_icb_cmd_ready = 1'b1;
        rst_n  = 1'b1;
        rsp_en = 1'b1;

        // Aligned load word, byte/half loads with extension, bus error
        issue(32'h1000, 1, 2'b10, 0, 32'h0, 4'h1, 32'hDEADBEEF, 0, 32'hDEADBEEF, w);
        issue(32'h2003, 1, 2'b00, 0, 32'h0, 4'h2, 32'h80123456, 0, 32'hFFFFFF80, w);
        issue(32'h2003, 1, 2'b00, 1, 32'h0, 4'h3, 32'h80123456, 0, 32'h00000080, w);
        issue(32'h2002, 1, 2'b01, 1, 32'h0, 4'h4, 32'hBEEF0000, 0, 32'h0000BEEF, w);
        issue(32'h2002, 1, 2'b01, 0, 32'h0, 4'h5, 32'h80010000, 0, 32'hFFFF8001, w);
        issue(32'h2001, 1, 2'b00, 0, 32'h0, 4'h6, 32'h00007F00, 0, 32'h0000007F, w);
        issue(32'h5000, 1, 2'b10, 0, 32'h0, 4'h7, 32'h12345678, 1, 32'h0, w);
        drain();

        // Half store: mask 0xC, write-back data forced to zero
        issue(32'h3002, 0, 2'b01, 0, 32'h12341234, 4'h8, 32'hFFFFFFFF, 0, 32'h0, w);
        drain();

        // Misaligned word: local error one cycle after acceptance
        issue(32'h1001, 1, 2'b10, 0, 32'h0, 4'h9, 32'h0, 0, 32'h0, w);
        @(negedge clk);
        check("mis_o_valid", lsu_o_valid, 1);
        check("mis_err",     lsu_o_wbck_err, 1);
        check("mis_badaddr", lsu_o_badaddr, 32'h1001);
        drain();
        issue(32'h2001, 1, 2'b01, 0, 32'h0, 4'hA, 32'h0, 0, 32'h0, w);
        drain();

        // Misaligned behind a pending bus load stays in order
        rsp_en = 1'b0;
        issue(32'h4000, 1, 2'b10, 0, 32'h0, 4'hB, 32'hCAFEF00D, 0, 32'hCAFEF00D, w);
        issue(32'h1001, 1, 2'b10, 0, 32'h0, 4'hC, 32'h0, 0, 32'h0, w);
        repeat (3) begin
            @(negedge clk);
            check("mis_waits_behind_load", lsu_o_valid, 0);
        end
        @(posedge clk);
        #1;
        rsp_en = 1'b1;
        drain();

        // Full backpressure
        rsp_en = 1'b0;
        issue(32'h6000, 1, 2'b10, 0, 32'h0, 4'h1, 32'h11111111, 0, 32'h11111111, w);
        issue(32'h6004, 1, 2'b10, 0, 32'h0, 4'h2, 32'h22222222, 0, 32'h22222222, w);
        @(posedge clk);
        #1;
        agu_cmd_addr  = 32'h6008;
        agu_cmd_read  = 1'b1;
        agu_cmd_size  = 2'b10;
        agu_cmd_itag  = 4'h3;
        agu_cmd_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("full_cmd_ready", agu_cmd_ready, 0);
            check("full_no_issue",  lsu_icb_cmd_valid, 0);
        end
        @(posedge clk);
        #1;
        lsu_o_ready = 1'b0;
        rsp_en      = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("stall_rsp_ready", lsu_icb_rsp_ready, 0);
            check("stall_o_valid",   lsu_o_valid, 1);
        end
        @(posedge clk);
        #1;
        lsu_o_ready = 1'b1;
        @(negedge clk);
        check("full_pop_no_bypass", agu_cmd_ready, 0);
        issue(32'h6008, 1, 2'b10, 0, 32'h0, 4'h3, 32'h33333333, 0, 32'h33333333, w);
        check("full_accept_next_cycle", w, 0);
        drain();

        // Reset mid-operation
        rsp_en = 1'b0;
        issue(32'h7000, 1, 2'b10, 0, 32'h0, 4'h5, 32'h55555555, 0, 32'h55555555, w);
        issue(32'h7004, 1, 2'b10, 0, 32'h0, 4'h6, 32'h66666666, 0, 32'h66666666, w);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        bus_q.delete();
        @(negedge clk);
        check("midrst_o_valid",   lsu_o_valid, 0);
        check("midrst_rsp_ready", lsu_icb_rsp_ready, 0);
        check("midrst_bus_valid", lsu_icb_cmd_valid, 0);
        check("midrst_err",       lsu_o_wbck_err, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus_q.push_back('{rdata: 32'hBAADBAAD, err: 1'b0});
        rsp_en = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("late_rsp_not_acked", lsu_icb_rsp_ready, 0);
            check("late_rsp_no_wb",     lsu_o_valid, 0);
        end
        @(posedge clk);
        #1;
        bus_q.delete();
        issue(32'h7008, 1, 2'b10, 0, 32'h0, 4'h7, 32'h0BADF00D, 0, 32'h0BADF00D, w);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/exu_lsu_ctrl.md
# exu_lsu_ctrl

Load/store control stage directly downstream of the ALU-shared AGU. It accepts address-generated load/store commands, checks alignment, and issues byte-masked requests on the data-memory bus. It tracks outstanding requests in an in-order FIFO, then aligns and sign- or zero-extends load data. Each instruction is written back to the long-pipe commit interface with its instruction tag.

## Interface
Parameters:
- OUTS_DEPTH, 2, maximum outstanding requests, including local misaligned entries; power of two, ≥2.
- XLEN, ADDR_SIZE, ITAG_WIDTH, from `defines.v` (XLEN = 32).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous assertion, active-low.
- agu_cmd_valid  in  1  command valid.
- agu_cmd_ready  out  1  command ready.
- agu_cmd_addr  in  ADDR_SIZE  byte address.
- agu_cmd_read  in  1  1 = load, 0 = store.
- agu_cmd_wdata  in  XLEN  store data, already lane-replicated by the AGU.
- agu_cmd_size  in  2  00 = byte, 01 = half, 10 = word.
- agu_cmd_usign  in  1  zero-extend load.
- agu_cmd_itag  in  ITAG_WIDTH  instruction tag.
- lsu_icb_cmd_valid / lsu_icb_cmd_ready  out / in  1  bus command handshake.
- lsu_icb_cmd_addr  out  ADDR_SIZE  word-aligned address (bits [1:0] = 0).
- lsu_icb_cmd_read  out  1  read.
- lsu_icb_cmd_wdata  out  XLEN  write data.
- lsu_icb_cmd_wmask  out  4  byte enables.
- lsu_icb_rsp_valid / lsu_icb_rsp_ready  in / out  1  bus response handshake.
- lsu_icb_rsp_rdata  in  XLEN  read word.
- lsu_icb_rsp_err  in  1  bus error.
- lsu_o_valid / lsu_o_ready  out / in  1  write-back handshake.
- lsu_o_wbck_wdat  out  XLEN  load result; 0 for stores.
- lsu_o_wbck_itag  out  ITAG_WIDTH  tag.
- lsu_o_wbck_err  out  1  misaligned or bus error.
- lsu_o_badaddr  out  ADDR_SIZE  full byte address of the faulting access.

## Operation
- **Misalignment:**
  - half with addr[0] = 1 is misaligned;
  - word with addr[1:0] ≠ 0 is misaligned;
  - byte is never misaligned.
- **Command acceptance:** agu_cmd_ready = ~full & (misaligned | lsu_icb_cmd_ready). An accepted command pushes one FIFO entry {itag, read, size, usign, addr, misaligned}.
- **Bus issue:** lsu_icb_cmd_valid = agu_cmd_valid & ~full & ~misaligned. All bus command fields are combinational from agu_cmd_*. A misaligned command is never issued to the bus.
- **wmask:**
  - byte: 4'b0001 << addr[1:0];
  - half: 4'b0011 << {addr[1], 1'b0};
  - word: 4'b1111.
  - Loads also drive this mask.
- **Head-of-FIFO write-back:**
  - local entry (misaligned): lsu_o_valid = 1, err = 1, wdat = 0; no bus response is consumed.
  - bus entry: lsu_o_valid = lsu_icb_rsp_valid; lsu_icb_rsp_ready = lsu_o_ready; err = lsu_icb_rsp_err.
  - lsu_icb_rsp_ready = 0 while the FIFO is empty or the head entry is local.
  - The entry pops on the lsu_o handshake.
- **Load data:**
  - s = rdata >> (8·addr[1:0]).
  - byte: bits [7:0], extended from bit 7 (or zero if usign).
  - half: bits [15:0], extended from bit 15.
  - word: s.
  - Store entries and error entries write back wdat = 0.
- **lsu_o_badaddr:** head entry's address whenever err = 1, else 0.
- **Ordering:** write-backs leave strictly in acceptance order; the bus returns responses in order.

## Timing
- **Reset:**
  - FIFO empty, pointers and count 0.
  - agu_cmd_ready = 0 only if the bus command ready is low; lsu_icb_cmd_valid = 0; lsu_o_valid = 0; lsu_icb_rsp_ready = 0; err = 0; badaddr = 0.
- **Reset mid-operation:** all outstanding entries are discarded; late bus responses after reset are not accepted until the next entry is pushed.
- **Latency:**
  - command → bus issue: 0 cycles (combinational);
  - bus response → write-back: 0 cycles (combinational);
  - misaligned entry → write-back: earliest 1 cycle after acceptance (registered FIFO).
- **Full:** count == OUTS_DEPTH blocks push even if a pop occurs in the same cycle (no bypass).
- **Simultaneous push and pop when not full:** count is unchanged, and both pointers advance modulo OUTS_DEPTH.
- **Empty:** a bus response while the FIFO is empty is a protocol violation; it is not acknowledged.
- **Write-back stall:** lsu_o_ready = 0 holds lsu_icb_rsp_ready low; the bus must hold its response stable.

## Test plan
- **Aligned load word:** lw addr 0x1000 → bus addr 0x1000, wmask 0xF; rsp rdata 0xDEADBEEF → wbck_wdat 0xDEADBEEF, err 0, itag matches.
- **Byte loads with extension:** lb addr 0x2003, rdata 0x80123456 → wdat 0xFFFFFF80; lbu at the same address → 0x00000080; lhu addr 0x2002, rdata 0xBEEF0000 → 0x0000BEEF.
- **Half store mask:** sh addr 0x3002, wdata 0x12341234 → wmask 0xC, bus addr 0x3000, write-back wdat 0.
- **Misaligned load:** lw addr 0x1001 → no bus command; next cycle lsu_o_valid = 1, err = 1, badaddr 0x1001. Repeat the same command behind one pending bus load: the misaligned error writes back only after the earlier load completes.
- **Full backpressure:** OUTS_DEPTH = 2, bus responses withheld: two loads accepted, third sees agu_cmd_ready = 0. Then release one response with lsu_o_ready = 1: the third load is accepted on the following cycle. Also hold lsu_o_ready = 0: lsu_icb_rsp_ready stays 0.
- **Reset mid-operation:** assert rst_n low with 2 entries pending → FIFO empty, all valid outputs 0; after release, a new lw completes normally.
